// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial add/subtract datapath.
//   state_t   : sequencer states of the bit-serial unit
//   OP_ADD/SUB: encodings of the op select input
//   DEF_WIDTH : default operand width
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   DEF_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_of.sv
// Bit-serial signed adder/subtractor with two's-complement overflow flag.
// One bit is resolved per clock through a single full adder and a carry flop.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only while busy=0 (IDLE or DONE)
//   op       : 0 = a+b, 1 = a-b (latched with start)
//   a, b     : two's-complement operands (latched with start)
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when result/carry/of become valid
//   result   : a+b or a-b modulo 2^WIDTH
//   carry    : carry out for add, borrow for subtract
//   of       : signed overflow
module serial_addsub_of
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             of
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             cf;
    logic             op_q;
    logic             c_msb_in;
    logic             fa_s, fa_co;

    assign last     = (cnt == CW'(WIDTH - 1));
    // Carry into the bit being processed; on the final step that is the
    // carry into the MSB, which overflow is judged against.
    assign c_msb_in = cf;

    full_adder u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (cf),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            result <= '0;
            cnt    <= '0;
            cf     <= 1'b0;
            op_q   <= OP_ADD;
            carry  <= 1'b0;
            of     <= 1'b0;
        end else if (accept) begin
            sa   <= a;
            // Subtract is a + ~b + 1: invert b here and seed the carry with op.
            sb   <= (op == OP_SUB) ? ~b : b;
            cf   <= op;
            op_q <= op;
            cnt  <= '0;
        end else if (state == RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            result <= {fa_s, result[WIDTH-1:1]};
            cf     <= fa_co;
            cnt    <= cnt + 1'b1;
            if (last) begin
                carry <= (op_q == OP_SUB) ? ~fa_co : fa_co;
                of    <= c_msb_in ^ fa_co;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: doc/serial_addsub_of.md
# serial_addsub_of

Bit-serial signed adder/subtractor with two's-complement overflow detection. It is the sequential counterpart of the combinational 4-bit ripple adder with overflow flag. It resolves one bit per clock through a single full-adder cell and a carry flop, and posts sum/difference, carry/borrow and overflow under a start/done handshake. It sits beside the combinational adder in the arithmetic datapath where area matters more than latency.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1: sole clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request pulse; sampled only when `busy`=0.
- `op`  in  1: operation select; 0 = a+b, 1 = a−b; latched with `start`.
- `a`  in  WIDTH: operand A, two's complement; latched with `start`.
- `b`  in  WIDTH: operand B, two's complement; latched with `start`.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse when results become valid.
- `result`  out  WIDTH: a+b or a−b, modulo 2^WIDTH.
- `carry`  out  1: carry out of the MSB for add; borrow (= NOT carry-out) for subtract.
- `of`  out  1: signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- States:
  - IDLE: reset state; `busy`=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Transitions:
  - IDLE or DONE with `start`=1 → RUN.
  - RUN → DONE after WIDTH bit steps.
  - DONE with `start`=0 → IDLE.
- On accept:
  - Latch A into shift register `sa`.
  - Latch `op` ? ~b : b into shift register `sb`.
  - Carry flop ← `op`, so subtract is A + ~B + 1.
  - Bit counter ← 0.
- Each RUN cycle:
  - The full adder takes `sa[0]`, `sb[0]` and the carry flop.
  - The sum bit shifts into the result register's MSB and everything shifts right.
  - The carry flop takes the new carry.
  - The carry-in of the current bit is also recorded in `c_msb_in` (it only matters on the final step).
  - The counter increments.
- On the final step (counter = WIDTH−1):
  - `carry` ← `op` ? ~cout : cout.
  - `of` ← `c_msb_in` XOR cout.
- `result`, `carry` and `of` hold their values from DONE until the next accepted start.
  - The result register shifts during RUN, so `result` is only meaningful when `busy`=0.
- `start` while `busy`=1 is ignored: no queueing, and the in-flight operands are not disturbed.
- `start` in the DONE cycle is accepted. Back-to-back operations therefore cost WIDTH+1 cycles each.
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `carry`=0, `of`=0; carry flop 0; counter 0.
- `rst` in any state, including mid-RUN, aborts the operation. All outputs go to their reset values on that edge, and no `done` is issued for the aborted operation.
- `rst` wins over a simultaneous `start`.

## Timing
- `start` sampled at edge T:
  - `busy`=1 from T.
  - Bits 0..WIDTH−1 are resolved at edges T+1..T+WIDTH.
  - At edge T+WIDTH: `busy` falls, `done` rises, and `result`, `carry` and `of` are valid.
- Latency from start to done is WIDTH cycles; `done` lasts exactly one cycle.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package `arith_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Op encodings OP_ADD=0, OP_SUB=1.
  - Default width constant 4.
- Reuse the existing `full_adder` cell as the single sub-module, instantiated once.
- Counter width is $clog2(WIDTH)+1.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst` 2 cycles; hold `start`=1 during reset.
  - Response: all outputs 0, state IDLE, no `done`.
- Subtract, no overflow (WIDTH=4):
  - a=0101, b=0011, op=1 → after 4 cycles `done` pulses; `result`=0010, `carry`=0, `of`=0.
  - a=0011, b=0101, op=1 → `result`=1110, `carry`=1 (borrow), `of`=0.
- Subtract, overflow:
  - a=0111, b=1111, op=1 → `result`=1000, `of`=1, `carry`=1.
  - a=1000, b=0001, op=1 → `result`=0111, `of`=1, `carry`=0.
- Add, overflow:
  - a=0111, b=0001, op=0 → `result`=1000, `of`=1, `carry`=0.
  - a=1000, b=1000, op=0 → `result`=0000, `of`=1, `carry`=1.
- Handshake:
  - `start` pulsed at cycle 2 of RUN with different operands → ignored; original result delivered on schedule.
  - `start` held in the DONE cycle → new RUN begins immediately; `done` pulses every 5 cycles.
- Reset mid-operation:
  - `rst` at cycle 2 of RUN → outputs return to 0 next edge; no `done`.
  - A subsequent start completes correctly.
